// File: rtl/router_pkt_rx.sv
// Router 1x3 input stage: header decode, per-packet steering into one of the
// destination FIFOs through a 1-deep output register, and parity checking.
module router_pkt_rx #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned LEN_W     = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 pkt_valid,
  output logic                 busy,
  output logic                 error,
  output logic                 pkt_done,
  input  logic [NUM_PORTS-1:0] fifo_full,
  output logic [NUM_PORTS-1:0] wr_en,
  output logic [DATA_W-1:0]    fifo_din
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   parity_q, parity_d;
  logic                drop_q, drop_d;
  logic                out_full_q, out_full_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_dest_q, out_dest_d;
  logic                error_q, error_d;
  logic                pkt_done_q, pkt_done_d;

  logic                dest_full;
  logic                accept;
  logic                load;
  logic [ADDR_W-1:0]   hdr_addr;
  logic [LEN_W-1:0]    hdr_len;
  logic                hdr_drop;

  // Full flag of the FIFO the held byte is headed for (0 for an invalid dest).
  always_comb begin
    dest_full = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (out_dest_q == ADDR_W'(i)) dest_full = fifo_full[i];
    end
  end

  // One-hot FIFO write strobe; a byte still held while reset is asserted is discarded.
  always_comb begin
    wr_en = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      wr_en[i] = out_full_q & ~reset & (out_dest_q == ADDR_W'(i)) & ~fifo_full[i];
    end
  end

  assign busy     = out_full_q & dest_full;
  assign accept   = pkt_valid & ~busy;
  assign hdr_addr = data_in[ADDR_W-1:0];
  assign hdr_len  = LEN_W'(data_in >> ADDR_W);
  assign hdr_drop = (32'(hdr_addr) >= 32'(NUM_PORTS));

  assign error    = error_q;
  assign pkt_done = pkt_done_q;
  assign fifo_din = out_data_q;

  // Next-state, packet bookkeeping and output-register load/drain.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    parity_d   = parity_q;
    drop_d     = drop_q;
    out_full_d = out_full_q;
    out_data_d = out_data_q;
    out_dest_d = out_dest_q;
    error_d    = 1'b0;
    pkt_done_d = 1'b0;
    load       = 1'b0;

    // Held byte drains whenever its FIFO has room.
    if (out_full_q && !dest_full) out_full_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d      = hdr_len;
          parity_d   = data_in;
          drop_d     = hdr_drop;
          out_dest_d = hdr_addr;
          load       = ~hdr_drop;
          state_d    = (hdr_len == '0) ? PARITY : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          parity_d = parity_q ^ data_in;
          cnt_d    = cnt_q - LEN_W'(1);
          load     = ~drop_q;
          if (cnt_q == LEN_W'(1)) state_d = PARITY;
        end
      end
      PARITY: begin
        if (accept) begin
          load       = ~drop_q;
          pkt_done_d = 1'b1;
          error_d    = (data_in != parity_q) | drop_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      out_full_d = 1'b1;
      out_data_d = data_in;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      parity_q   <= '0;
      drop_q     <= 1'b0;
      out_full_q <= 1'b0;
      out_data_q <= '0;
      out_dest_q <= '0;
      error_q    <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      parity_q   <= parity_d;
      drop_q     <= drop_d;
      out_full_q <= out_full_d;
      out_data_q <= out_data_d;
      out_dest_q <= out_dest_d;
      error_q    <= error_d;
      pkt_done_q <= pkt_done_d;
    end
  end

endmodule
